// File: rtl/array_checker_pkg.sv
// Shared types and constants for the array_checker block: FSM state encoding
// and the byte stride between consecutive array elements.
package array_checker_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int BYTE_W = 8;

  // Byte distance between neighbouring elements of width data_w.
  function automatic int elem_stride(input int data_w);
    return data_w / BYTE_W;
  endfunction

endpackage

// File: rtl/array_checker_halt_detector.sv
// halt_detector: emits a one-cycle halted pulse once pc has stayed unchanged
// for HALT_CYCLES consecutive cycles; rearms when pc moves again.
module halt_detector #(
  parameter int ADDR_W      = 16,
  parameter int HALT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic              halted
);

  localparam int CNT_W = $clog2(HALT_CYCLES + 1);

  logic [ADDR_W-1:0] pc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              armed_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b1;
      halted  <= 1'b0;
    end else begin
      pc_q   <= pc;
      halted <= 1'b0;
      if (pc != pc_q) begin
        cnt_q   <= '0;
        armed_q <= 1'b1;
      end else if (armed_q) begin
        // Fire once per halt; stay disarmed until pc changes.
        if (cnt_q == CNT_W'(HALT_CYCLES - 1)) begin
          halted  <= 1'b1;
          armed_q <= 1'b0;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/array_checker.sv
// array_checker: streams an array from data memory, checks it is monotonic and
// sums it. Optional halt-triggered auto-start: ARRAY_CHECKER_HALT_TRIGGER_EN.
module array_checker
  import array_checker_pkg::*;
#(
  parameter int                DATA_W         = 32,
  parameter int                ADDR_W         = 16,
  parameter int                LEN_W          = 10,
  parameter int                HALT_CYCLES    = 64,
  parameter logic [ADDR_W-1:0] DEFAULT_BASE   = '0,
  parameter logic [LEN_W-1:0]  DEFAULT_LEN    = '0,
  parameter bit                DEFAULT_DESC   = 1'b0,
  parameter bit                DEFAULT_SIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              descending,
  input  logic              signed_cmp,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [LEN_W-1:0]  fail_index,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(elem_stride(DATA_W));

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cfg_base_q, addr_q;
  logic [LEN_W-1:0]  cfg_len_q, issue_cnt_q, elem_idx_q, fail_idx_q;
  logic              cfg_desc_q, cfg_sgn_q;
  logic              rd_vld_q, pass_q;
  logic [DATA_W-1:0] prev_q, csum_q;
  logic              trig, accept;
  logic [ADDR_W-1:0] op_base;
  logic [LEN_W-1:0]  op_len;
  logic              op_desc, op_sgn;

`ifdef ARRAY_CHECKER_HALT_TRIGGER_EN
  logic halted;

  halt_detector #(
    .ADDR_W      (ADDR_W),
    .HALT_CYCLES (HALT_CYCLES)
  ) u_halt_detector (
    .clk    (clk),
    .rst    (rst),
    .pc     (pc),
    .halted (halted)
  );

  assign trig = start | halted;
`else
  logic pc_unused;
  localparam int HALT_CYCLES_UNUSED = HALT_CYCLES;
  assign pc_unused = ^pc;
  assign trig      = start;
`endif

  // A port start always wins; an auto-start reuses the last sampled operands.
  assign accept  = (state_q == S_IDLE) && trig;
  assign op_base = start ? base_addr  : cfg_base_q;
  assign op_len  = start ? length     : cfg_len_q;
  assign op_desc = start ? descending : cfg_desc_q;
  assign op_sgn  = start ? signed_cmp : cfg_sgn_q;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = (op_len == '0) ? S_DRAIN : S_ISSUE;
      S_ISSUE: if (issue_cnt_q == LEN_W'(1)) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  assign rd_en      = (state_q == S_ISSUE);
  assign rd_addr    = addr_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign pass       = pass_q;
  assign fail_index = fail_idx_q;
  assign checksum   = csum_q;

  // Zero-extend or sign-extend one bit so a single signed compare covers both modes.
  logic signed [DATA_W:0] cur_x, prev_x;
  logic                   violation;

  assign cur_x     = $signed({cfg_sgn_q & rd_data[DATA_W-1], rd_data});
  assign prev_x    = $signed({cfg_sgn_q & prev_q[DATA_W-1], prev_q});
  assign violation = cfg_desc_q ? (cur_x > prev_x) : (cur_x < prev_x);

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_base_q  <= DEFAULT_BASE;
      cfg_len_q   <= DEFAULT_LEN;
      cfg_desc_q  <= DEFAULT_DESC;
      cfg_sgn_q   <= DEFAULT_SIGNED;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      elem_idx_q  <= '0;
      rd_vld_q    <= 1'b0;
      pass_q      <= 1'b0;
      fail_idx_q  <= '0;
      csum_q      <= '0;
    end else begin
      rd_vld_q <= rd_en;
      if (accept) begin
        cfg_base_q  <= op_base;
        cfg_len_q   <= op_len;
        cfg_desc_q  <= op_desc;
        cfg_sgn_q   <= op_sgn;
        addr_q      <= op_base;
        issue_cnt_q <= op_len;
        elem_idx_q  <= '0;
        pass_q      <= 1'b1;
        fail_idx_q  <= '0;
        csum_q      <= '0;
      end else if (rd_en) begin
        addr_q      <= addr_q + STRIDE;
        issue_cnt_q <= issue_cnt_q - 1'b1;
      end
      if (rd_vld_q) begin
        csum_q     <= csum_q + rd_data;
        elem_idx_q <= elem_idx_q + 1'b1;
        if ((elem_idx_q != '0) && violation && pass_q) begin
          pass_q     <= 1'b0;
          fail_idx_q <= elem_idx_q;
        end
      end
    end
  end

  // NOTE: prev_q is pure datapath, only read after it has been written in the
  // current scan, so it carries no reset and reset does not gate its enable.
  always_ff @(posedge clk) begin
    if (rd_vld_q) prev_q <= rd_data;
  end

endmodule

// File: tb/tb_array_checker.sv
// Self-checking bench for array_checker: directed scans with a scoreboard
// monitor that checks every rd_addr and every done result against queues.
module tb_array_checker;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int LEN_W  = 10;
  localparam int HALT_C = 8;

  typedef struct {
    logic             pass;
    logic [LEN_W-1:0] fi;
    logic [DATA_W-1:0] cs;
    int               lat;
    bit               chk_lat;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  length = '0;
  logic              descending = 1'b0;
  logic              signed_cmp = 1'b0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] pc = '0;
  logic              busy, done, pass;
  logic [LEN_W-1:0]  fail_index;
  logic [DATA_W-1:0] checksum;

  logic [DATA_W-1:0] mem [0:16383];
  exp_t              exp_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  exp_t              mon_e;
  logic [ADDR_W-1:0] mon_a;
  int                checks = 0;
  int                failures = 0;
  int                cyc = 0;
  int                start_cyc = 0;
  bit                pc_hold = 1'b0;

  array_checker #(
    .DATA_W         (DATA_W),
    .ADDR_W         (ADDR_W),
    .LEN_W          (LEN_W),
    .HALT_CYCLES    (HALT_C),
    .DEFAULT_BASE   (16'h0200),
    .DEFAULT_LEN    (10'd3),
    .DEFAULT_DESC   (1'b0),
    .DEFAULT_SIGNED (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .descending (descending),
    .signed_cmp (signed_cmp),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .pc         (pc),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_index (fail_index),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory: data appears the cycle after the strobe.
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr[15:2]] : 32'hDEAD_BEEF;

  initial forever begin
    @(negedge clk);
    if (!pc_hold) pc = pc + 16'd4;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected address per strobe and one result per done.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_en) begin
        if (addr_q.size() == 0) check("spurious_rd_en", rd_en, 1'b0);
        else begin
          mon_a = addr_q.pop_front();
          check("rd_addr", rd_addr, mon_a);
        end
      end
      if (done) begin
        if (exp_q.size() == 0) check("spurious_done", done, 1'b0);
        else begin
          mon_e = exp_q.pop_front();
          check("done_pass", pass, mon_e.pass);
          check("done_fail_index", fail_index, mon_e.fi);
          check("done_checksum", checksum, mon_e.cs);
          // Latency counts the clock edge that samples done.
          if (mon_e.chk_lat) check("done_latency", cyc + 1 - start_cyc, mon_e.lat);
        end
      end
    end
  end

  task automatic set_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
    mem[a[15:2]] = v;
  endtask

  task automatic push_addrs(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len);
    for (int k = 0; k < int'(len); k++) addr_q.push_back(base + ADDR_W'(4 * k));
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len,
                             input bit desc, input bit sgn);
    @(negedge clk);
    start = 1'b1; base_addr = base; length = len; descending = desc; signed_cmp = sgn;
    @(posedge clk);
    #1 start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("busy_timeout", busy, 1'b0);
  endtask

  task automatic run(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len,
                     input bit desc, input bit sgn, input bit e_pass,
                     input logic [LEN_W-1:0] e_fi, input logic [DATA_W-1:0] e_cs);
    exp_t e;
    e.pass = e_pass; e.fi = e_fi; e.cs = e_cs; e.lat = int'(len) + 2; e.chk_lat = 1'b1;
    push_addrs(base, len);
    exp_q.push_back(e);
    pulse_start(base, len, desc, sgn);
    check("busy_after_start", busy, 1'b1);
    wait_idle(int'(len) + 10);
    check("hold_pass", pass, e_pass);
    check("hold_fail_index", fail_index, e_fi);
    check("hold_checksum", checksum, e_cs);
  endtask

  initial begin
    logic [DATA_W-1:0] mixed [10];
    logic [DATA_W-1:0] sdat [4];
    logic [DATA_W-1:0] ddat [4];
    mixed = '{32'd5, 32'd3, 32'd9, 32'd1, 32'd2, 32'd4, 32'd6, 32'd7, 32'd8, 32'd10};
    sdat  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd0, 32'd7};
    ddat  = '{32'd9, 32'd9, 32'd4, 32'd1};
    for (int i = 0; i < 16384; i++) mem[i] = '0;
    for (int k = 0; k < 10; k++) set_word(16'd4336 + 16'(4 * k), 32'(k + 1));
    for (int k = 0; k < 10; k++) set_word(16'h2000 + 16'(4 * k), mixed[k]);
    for (int k = 0; k < 4; k++)  set_word(16'h3000 + 16'(4 * k), sdat[k]);
    for (int k = 0; k < 4; k++)  set_word(16'h4000 + 16'(4 * k), ddat[k]);
    set_word(16'hFFFC, 32'd20);
    set_word(16'h0000, 32'd10);
    set_word(16'h5000, 32'd100);
    set_word(16'h5004, 32'd1);

    repeat (3) @(negedge clk);
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_rd_addr", rd_addr, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_fail_index", fail_index, 10'd0);
    check("rst_checksum", checksum, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run(16'd4336, 10'd10, 1'b0, 1'b0, 1'b1, 10'd0, 32'd55);
    run(16'h2000, 10'd10, 1'b0, 1'b0, 1'b0, 10'd1, 32'd55);
    run(16'h3000, 10'd4,  1'b0, 1'b1, 1'b1, 10'd0, 32'd3);
    run(16'h3000, 10'd4,  1'b0, 1'b0, 1'b0, 10'd2, 32'd3);
    run(16'h4000, 10'd4,  1'b1, 1'b0, 1'b1, 10'd0, 32'd23);
    run(16'h4000, 10'd0,  1'b0, 1'b0, 1'b1, 10'd0, 32'd0);
    run(16'hFFFC, 10'd2,  1'b0, 1'b0, 1'b0, 10'd1, 32'd30);

    // Reset three cycles into a scan: abort with no done and no more strobes.
    push_addrs(16'd4336, 10'd10);
    pulse_start(16'd4336, 10'd10, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_rd_en", rd_en, 1'b0);
    check("abort_done", done, 1'b0);
    addr_q.delete();
    rst = 1'b0;
    repeat (15) @(negedge clk);

    // A second start while busy must be ignored.
    begin
      exp_t e;
      e.pass = 1'b1; e.fi = 10'd0; e.cs = 32'd3; e.lat = 6; e.chk_lat = 1'b1;
      push_addrs(16'h3000, 10'd4);
      exp_q.push_back(e);
      pulse_start(16'h3000, 10'd4, 1'b0, 1'b1);
      @(negedge clk);
      start = 1'b1; base_addr = 16'h5000; length = 10'd2; descending = 1'b0; signed_cmp = 1'b0;
      @(negedge clk);
      start = 1'b0;
      wait_idle(20);
      check("ignored_start_checksum", checksum, 32'd3);
      repeat (5) @(negedge clk);
    end

`ifdef ARRAY_CHECKER_HALT_TRIGGER_EN
    // Holding pc auto-starts exactly once with the last sampled operands.
    run(16'd4336, 10'd3, 1'b0, 1'b0, 1'b1, 10'd0, 32'd6);
    begin
      exp_t e;
      int n;
      e.pass = 1'b1; e.fi = 10'd0; e.cs = 32'd6; e.lat = 0; e.chk_lat = 1'b0;
      push_addrs(16'd4336, 10'd3);
      exp_q.push_back(e);
      pc_hold = 1'b1;
      n = 0;
      while (!busy && n < HALT_C + 20) begin
        @(negedge clk);
        n++;
      end
      check("halt_autostart", busy, 1'b1);
      wait_idle(20);
      repeat (3 * HALT_C) @(negedge clk);
      check("halt_single_fire", busy, 1'b0);
      pc_hold = 1'b0;
      repeat (4) @(negedge clk);
    end
`endif

    check("scoreboard_results_left", 32'(exp_q.size()), 32'd0);
    check("scoreboard_addrs_left", 32'(addr_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/array_checker.md
ARRAY_CHECKER -- requirements
Module: array_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning element width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 16, meaning data-memory byte-address width.
REQ-003 SHALL have parameter LEN_W, default 10, meaning element-count width; max length 2^LEN_W-1.
REQ-004 SHALL have parameter HALT_CYCLES, default 64, meaning unchanged-PC cycles that count as program halt.
REQ-005 SHALL have port clk  input  1  the only clock.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port start  input  1  one-cycle request to begin a check.
REQ-008 SHALL have port base_addr  input  ADDR_W  byte address of element 0, sampled with start.
REQ-009 SHALL have port length  input  LEN_W  element count, sampled with start.
REQ-010 SHALL have port descending  input  1  0 = check non-decreasing, 1 = non-increasing; sampled with start.
REQ-011 SHALL have port signed_cmp  input  1  1 = two's-complement compare; sampled with start.
REQ-012 SHALL have port rd_en  output  1  memory read strobe.
REQ-013 SHALL have port rd_addr  output  ADDR_W  memory byte address.
REQ-014 SHALL have port rd_data  input  DATA_W  read data, valid exactly one cycle after rd_en.
REQ-015 SHALL have port pc  input  ADDR_W  CPU fetch address (used only with halt trigger).
REQ-016 SHALL have ports busy, done, pass  output  1 each; fail_index  output  LEN_W; checksum  output  DATA_W.

Function
REQ-017 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE; start accepted only in IDLE, ignored otherwise.
REQ-018 SHALL in ISSUE assert rd_en for exactly length consecutive cycles, rd_addr = base_addr + k*(DATA_W/8) for k = 0..length-1, wrapping modulo 2^ADDR_W.
REQ-019 SHALL in DRAIN consume the final read datum, then enter DONE; done pulses high one cycle, exactly length+2 cycles after the start-sampling edge.
REQ-020 SHALL with length = 0 skip ISSUE (no rd_en) and pulse done 2 cycles after start with pass = 1.
REQ-021 SHALL compare each element k>=1 against element k-1 using signed_cmp/descending; equal elements pass.
REQ-022 SHALL on first violation latch fail_index = k and clear pass; later violations SHALL NOT alter fail_index; scan continues to fixed latency.
REQ-023 SHALL compute checksum as modulo-2^DATA_W sum of all elements read.
REQ-024 SHALL hold busy high from the cycle after start acceptance through the done cycle inclusive.
REQ-025 SHALL hold pass, fail_index, checksum stable from done until next accepted start; fail_index = 0 when pass = 1.

Reset
REQ-026 SHALL on rst: FSM to IDLE, rd_en = 0, rd_addr = 0, busy = 0, done = 0, pass = 0, fail_index = 0, checksum = 0, halt counter = 0.
REQ-027 SHALL on rst asserted mid-scan abort immediately with no done pulse and no further rd_en.

Configuration
REQ-028 SHALL with ARRAY_CHECKER_HALT_TRIGGER_EN defined: auto-start (using last sampled base_addr/length/mode registers loaded by parameter-defined defaults at reset) once pc has been unchanged for HALT_CYCLES consecutive cycles; trigger fires once per halt, rearms when pc changes.
REQ-029 SHALL with ARRAY_CHECKER_HALT_TRIGGER_EN undefined: pc ignored, checks begin only via start; no halt counter synthesised.
REQ-030 SHALL treat simultaneous start and halt trigger as one start, with start port operand values winning.

Structure
REQ-031 SHALL place FSM state enum and byte-stride constant in shared package array_checker_pkg.
REQ-032 SHALL implement halt detection in sub-module halt_detector (pc, HALT_CYCLES -> one-cycle halted pulse).

Verification
REQ-033 SHALL test: base 4336, length 10, data 1..10 ascending, descending=0 -> done at cycle 12, pass=1, checksum=55.
REQ-034 SHALL test: data {5,3,9,1,...}, length 10 -> pass=0, fail_index=1; done still at cycle 12.
REQ-035 SHALL test: signed_cmp=1, data {-3,-1,0,7} length 4 -> pass=1; same data signed_cmp=0 -> pass=0, fail_index=2.
REQ-036 SHALL test: length 0 -> no rd_en, done 2 cycles after start, pass=1, checksum=0; base 16'hFFFC length 2 -> rd_addr FFFC then 0000.
REQ-037 SHALL test: rst asserted 3 cycles into length-10 scan -> busy=0 and rd_en=0 next cycle, no done; start during busy ignored.
REQ-038 SHALL test (macro defined): pc held constant HALT_CYCLES cycles -> exactly one auto-start, none further until pc changes.
